// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings and alignment helper for the memory access controller
package mips_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_RD     = 3'd1;
   localparam state_t ST_RMW_RD = 3'd2;
   localparam state_t ST_WR     = 3'd3;
   localparam state_t ST_DONE   = 3'd4;
   localparam state_t ST_ERR    = 3'd5;

   // Halves must sit on even addresses, words on multiples of four; the reserved size always faults.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = |addr_lo;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian lane extract/extend for loads and lane merge for subword stores
module mem_lane_align
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        sgn,
   input  logic [15:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] store_word
);

   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   // Pick the addressed byte and half; offset 0 is the most significant lane.
   always_comb begin
      case (offset)
         2'd0:    lane_b = word[31:24];
         2'd1:    lane_b = word[23:16];
         2'd2:    lane_b = word[15:8];
         default: lane_b = word[7:0];
      endcase
      lane_h = offset[1] ? word[15:0] : word[31:16];
   end

   // Extend the extracted lane to 32 bits; word loads pass straight through.
   always_comb begin
      case (size)
         SZ_BYTE: load_val = {{24{sgn & lane_b[7]}}, lane_b};
         SZ_HALF: load_val = {{16{sgn & lane_h[15]}}, lane_h};
         default: load_val = word;
      endcase
   end

   // Replace only the addressed lane of the read word, leaving every other bit untouched.
   always_comb begin
      store_word = word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0:    store_word[31:24] = wdata[7:0];
               2'd1:    store_word[23:16] = wdata[7:0];
               2'd2:    store_word[15:8]  = wdata[7:0];
               default: store_word[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1])
               store_word[15:0] = wdata;
            else
               store_word[31:16] = wdata;
         end
         default: store_word = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store initiator with subword access and fault detection
module mem_access_ctrl
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req,
   input  logic              Wr,
   input  logic [1:0]        Size,
   input  logic              Signed,
   input  logic [ADDR_W-1:0] Addr,
   input  logic [31:0]       WData,
   output logic              Busy,
   output logic              Done,
   output logic              Err,
   output logic [31:0]       RData,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [31:0]       MemWData,
   input  logic [31:0]       MemRData
);

   state_t            state;
   state_t            state_nxt;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [ADDR_W-1:0] addr_q;
   logic [15:0]       wdata_q;
   logic [31:0]       mwdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       load_val;
   logic [31:0]       store_word;
   logic              accept;

   assign accept = (state == ST_IDLE) && Req;

   mem_lane_align u_align (
      .word       (MemRData),
      .offset     (addr_q[1:0]),
      .size       (size_q),
      .sgn        (signed_q),
      .wdata      (wdata_q),
      .load_val   (load_val),
      .store_word (store_word)
   );

   // State register; reset returns to IDLE immediately so a pending write is dropped.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: faults are decided at accept so no memory cycle is ever started for them.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (Req) begin
               if (is_misaligned(Size, Addr[1:0]))
                  state_nxt = ST_ERR;
               else if (!Wr)
                  state_nxt = ST_RD;
               else if (Size == SZ_WORD)
                  state_nxt = ST_WR;
               else
                  state_nxt = ST_RMW_RD;
            end
         end
         ST_RD:     state_nxt = ST_DONE;
         ST_RMW_RD: state_nxt = ST_WR;
         ST_WR:     state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         ST_ERR:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode from state alone, so read and write enables are mutually exclusive by construction.
   always_comb begin
      Busy     = (state != ST_IDLE);
      Done     = (state == ST_DONE);
      Err      = (state == ST_ERR);
      MemRead  = (state == ST_RD) || (state == ST_RMW_RD);
      MemWrite = (state == ST_WR);
   end

   // Request latches, write word assembly and the load result register.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         size_q   <= SZ_BYTE;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         mwdata_q <= '0;
         rdata_q  <= '0;
      end else begin
         if (accept) begin
            size_q   <= Size;
            signed_q <= Signed;
            addr_q   <= Addr;
            wdata_q  <= WData[15:0];
            mwdata_q <= WData;
         end
         if (state == ST_RMW_RD)
            mwdata_q <= store_word;
         if (state == ST_RD)
            rdata_q <= load_val;
      end
   end

   assign RData    = rdata_q;
   assign MemAddr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign MemWData = mwdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

   logic        Clk;
   logic        Rst;
   logic        Req;
   logic        Wr;
   logic [1:0]  Size;
   logic        Signed;
   logic [31:0] Addr;
   logic [31:0] WData;
   logic        Busy;
   logic        Done;
   logic        Err;
   logic [31:0] RData;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData;

   logic [31:0] mem [0:255];

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_ctrl #(.ADDR_W(32)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Req      (Req),
      .Wr       (Wr),
      .Size     (Size),
      .Signed   (Signed),
      .Addr     (Addr),
      .WData    (WData),
      .Busy     (Busy),
      .Done     (Done),
      .Err      (Err),
      .RData    (RData),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .MemAddr  (MemAddr),
      .MemWData (MemWData),
      .MemRData (MemRData)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Behavioural memory: combinational read, commit on posedge when MemWrite is high.
   assign MemRData = mem[MemAddr[9:2]];
   always @(posedge Clk) begin
      if (MemWrite)
         mem[MemAddr[9:2]] <= MemWData;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issue one request, then observe each cycle after the accept edge until Busy drops (bounded).
   task automatic run_op(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output int done_cyc, output int err_cyc, output int rd_cnt,
                         output int wr_cnt, output logic [31:0] mwd, output int proto_bad);
      done_cyc = 0; err_cyc = 0; rd_cnt = 0; wr_cnt = 0; mwd = '0; proto_bad = 0;
      @(negedge Clk);
      Req = 1'b1; Wr = wr; Size = sz; Signed = sg; Addr = ad; WData = wd;
      @(posedge Clk);
      #1 Req = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clk);
         if (MemRead) rd_cnt++;
         if (MemWrite) begin
            wr_cnt++;
            mwd = MemWData;
         end
         if (MemRead && MemWrite) proto_bad++;
         if (Done && Err) proto_bad++;
         if ((Done || Err) && !Busy) proto_bad++;
         if (Done && done_cyc == 0) done_cyc = c;
         if (Err && err_cyc == 0) err_cyc = c;
         if (!Busy) break;
      end
   endtask

   task automatic test_reset();
      #2;
      n_cmp++;
      if ({Busy, Done, Err, MemRead, MemWrite} !== 5'b0) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b expected 00000", {Busy, Done, Err, MemRead, MemWrite});
      end
      n_cmp++;
      if ({RData, MemAddr, MemWData} !== 96'h0) begin
         n_bad++;
         $display("FAIL reset_data: got RData=%h MemAddr=%h MemWData=%h expected all 0", RData, MemAddr, MemWData);
      end
      @(negedge Clk);
      @(negedge Clk);
      Rst = 1'b1;
   endtask

   task automatic test_load_byte();
      int dc, ec, rc, wc, pb;
      logic [31:0] mw;
      run_op(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (dc !== 2 || ec !== 0 || rc !== 1 || wc !== 0 || pb !== 0) begin
         n_bad++;
         $display("FAIL lb_signed_timing: got done=%0d err=%0d rd=%0d wr=%0d bad=%0d expected 2 0 1 0 0", dc, ec, rc, wc, pb);
      end
      n_cmp++;
      if (RData !== 32'hFFFFFF99) begin
         n_bad++;
         $display("FAIL lb_signed: got %h expected FFFFFF99", RData);
      end
      run_op(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'h00000099 || dc !== 2) begin
         n_bad++;
         $display("FAIL lb_unsigned: got %h done=%0d expected 00000099 done=2", RData, dc);
      end
      run_op(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'hFFFFFFBB) begin
         n_bad++;
         $display("FAIL lb_offset3: got %h expected FFFFFFBB", RData);
      end
   endtask

   task automatic test_subword_store();
      int dc, ec, rc, wc, pb;
      logic [31:0] mw;
      run_op(1'b1, 2'b00, 1'b0, 32'h102, 32'hFFFFFF5C, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (dc !== 3 || rc !== 1 || wc !== 1 || pb !== 0) begin
         n_bad++;
         $display("FAIL sb_timing: got done=%0d rd=%0d wr=%0d bad=%0d expected 3 1 1 0", dc, rc, wc, pb);
      end
      n_cmp++;
      if (mw !== 32'h88995CBB) begin
         n_bad++;
         $display("FAIL sb_merge: got %h expected 88995CBB", mw);
      end
      n_cmp++;
      if (RData !== 32'hFFFFFFBB) begin
         n_bad++;
         $display("FAIL sb_rdata_kept: got %h expected FFFFFFBB", RData);
      end
      run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'h88995CBB || dc !== 2) begin
         n_bad++;
         $display("FAIL sb_readback: got %h done=%0d expected 88995CBB done=2", RData, dc);
      end
   endtask

   task automatic test_word_store();
      int dc, ec, rc, wc, pb;
      logic [31:0] mw;
      run_op(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (dc !== 2 || rc !== 0 || wc !== 1 || mw !== 32'hDEADBEEF || pb !== 0) begin
         n_bad++;
         $display("FAIL sw_store: got done=%0d rd=%0d wr=%0d data=%h bad=%0d expected 2 0 1 DEADBEEF 0", dc, rc, wc, mw, pb);
      end
      run_op(1'b0, 2'b10, 1'b1, 32'h104, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL sw_readback: got %h expected DEADBEEF", RData);
      end
      run_op(1'b1, 2'b01, 1'b0, 32'h106, 32'hAAAA1234, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (dc !== 3 || mw !== 32'hDEAD1234) begin
         n_bad++;
         $display("FAIL sh_merge: got done=%0d data=%h expected 3 DEAD1234", dc, mw);
      end
   endtask

   task automatic test_faults();
      int dc, ec, rc, wc, pb;
      logic [31:0] mw;
      logic [1:0]  sz_tab [3];
      logic [31:0] ad_tab [3];
      sz_tab[0] = 2'b10; ad_tab[0] = 32'h102;
      sz_tab[1] = 2'b01; ad_tab[1] = 32'h103;
      sz_tab[2] = 2'b11; ad_tab[2] = 32'h000;
      for (int i = 0; i < 3; i++) begin
         run_op(1'b0, sz_tab[i], 1'b1, ad_tab[i], 32'h0, dc, ec, rc, wc, mw, pb);
         n_cmp++;
         if (ec !== 1 || dc !== 0 || rc !== 0 || wc !== 0 || pb !== 0) begin
            n_bad++;
            $display("FAIL fault_%0d: got err=%0d done=%0d rd=%0d wr=%0d bad=%0d expected 1 0 0 0 0", i, ec, dc, rc, wc, pb);
         end
         n_cmp++;
         if (RData !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL fault_rdata_%0d: got %h expected DEADBEEF", i, RData);
         end
      end
      run_op(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'hDEAD1234) begin
         n_bad++;
         $display("FAIL sh_readback: got %h expected DEAD1234", RData);
      end
   endtask

   task automatic test_held_req();
      logic [9:0] done_mask;
      logic [9:0] busy_mask;
      done_mask = '0;
      busy_mask = '0;
      @(negedge Clk);
      Req = 1'b1; Wr = 1'b0; Size = 2'b01; Signed = 1'b1; Addr = 32'h100; WData = 32'h0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge Clk);
         done_mask[c] = Done;
         busy_mask[c] = Busy;
      end
      Req = 1'b0;
      n_cmp++;
      if (done_mask !== 10'h124) begin
         n_bad++;
         $display("FAIL held_req_done: got %b expected %b", done_mask, 10'h124);
      end
      n_cmp++;
      if (busy_mask !== 10'h1B6) begin
         n_bad++;
         $display("FAIL held_req_busy: got %b expected %b", busy_mask, 10'h1B6);
      end
      n_cmp++;
      if (RData !== 32'hFFFF8899) begin
         n_bad++;
         $display("FAIL lh_signed: got %h expected FFFF8899", RData);
      end
      @(negedge Clk);
   endtask

   task automatic test_reset_mid_write();
      int dc, ec, rc, wc, pb;
      logic [31:0] mw;
      @(negedge Clk);
      Req = 1'b1; Wr = 1'b1; Size = 2'b00; Signed = 1'b0; Addr = 32'h100; WData = 32'h00000011;
      @(posedge Clk);
      #1 Req = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      n_cmp++;
      if (MemWrite !== 1'b1 || MemWData !== 32'h11995CBB) begin
         n_bad++;
         $display("FAIL rst_wr_cycle: got MemWrite=%b MemWData=%h expected 1 11995CBB", MemWrite, MemWData);
      end
      #1 Rst = 1'b0;
      #1;
      n_cmp++;
      if ({Busy, Done, Err, MemRead, MemWrite} !== 5'b0 || {RData, MemAddr, MemWData} !== 96'h0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got ctrl=%b RData=%h MemAddr=%h MemWData=%h expected all 0",
                  {Busy, Done, Err, MemRead, MemWrite}, RData, MemAddr, MemWData);
      end
      @(posedge Clk);
      #1;
      n_cmp++;
      if (mem[8'h40] !== 32'h88995CBB) begin
         n_bad++;
         $display("FAIL rst_no_commit: got %h expected 88995CBB", mem[8'h40]);
      end
      @(negedge Clk);
      Rst = 1'b1;
      run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, dc, ec, rc, wc, mw, pb);
      n_cmp++;
      if (RData !== 32'h88995CBB || dc !== 2 || ec !== 0) begin
         n_bad++;
         $display("FAIL rst_recover: got %h done=%0d err=%0d expected 88995CBB 2 0", RData, dc, ec);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h40] = 32'h8899AABB;
      Rst = 1'b0; Req = 1'b0; Wr = 1'b0; Size = 2'b00; Signed = 1'b0; Addr = '0; WData = '0;
      test_reset();
      test_load_byte();
      test_subword_store();
      test_word_store();
      test_faults();
      test_held_req();
      test_reset_mid_write();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
